// File: rtl/grf_pkg.sv
// Shared constants and types for the multiport general register file.
package grf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PC_W_DEF   = 32;

  // One committed write as seen on a trace lane ("reg" is a keyword, hence idx).
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] idx;
    logic [DATA_W_DEF-1:0] data;
    logic [PC_W_DEF-1:0]   pc;
  } trace_lane_t;

endpackage

// File: rtl/grf_multiport_if.sv
// Decode/writeback-facing bus of the register file: reads, two write ports, issue, trace.
interface grf_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int PC_W   = 32
);
  logic [NUM_RD*ADDR_W-1:0] ReadReg;
  logic [NUM_RD*DATA_W-1:0] ReadData;
  logic [NUM_RD-1:0]        ReadBusy;
  logic                     WeA, WeB;
  logic [ADDR_W-1:0]        WaA, WaB;
  logic [DATA_W-1:0]        WdA, WdB;
  logic [PC_W-1:0]          WpcA, WpcB;
  logic                     IssueEn;
  logic [ADDR_W-1:0]        IssueReg;
  logic [1:0]               TraceValid;
  logic [ADDR_W-1:0]        TraceRegA, TraceRegB;
  logic [DATA_W-1:0]        TraceDataA, TraceDataB;
  logic [PC_W-1:0]          TracePcA, TracePcB;

  modport master (
    output ReadReg, WeA, WaA, WdA, WpcA, WeB, WaB, WdB, WpcB, IssueEn, IssueReg,
    input  ReadData, ReadBusy, TraceValid, TraceRegA, TraceRegB,
           TraceDataA, TraceDataB, TracePcA, TracePcB
  );

  modport slave (
    input  ReadReg, WeA, WaA, WdA, WpcA, WeB, WaB, WdB, WpcB, IssueEn, IssueReg,
    output ReadData, ReadBusy, TraceValid, TraceRegA, TraceRegB,
           TraceDataA, TraceDataB, TracePcA, TracePcB
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Per-register busy vector: writes clear, issue sets, and issue wins on the same index.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_idx,
  input  logic                   clr_a_en,
  input  logic [ADDR_W-1:0]      clr_a_idx,
  input  logic                   clr_b_en,
  input  logic [ADDR_W-1:0]      clr_b_idx,
  output logic [(1<<ADDR_W)-1:0] busy
);
  logic [(1<<ADDR_W)-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_a_en) busy_d[clr_a_idx] = 1'b0;
    if (clr_b_en) busy_d[clr_b_idx] = 1'b0;
    // The newly issued producer supersedes a retiring one.
    if (issue_en) busy_d[issue_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: rtl/grf_multiport.sv
// Register file with NUM_RD bypassing read ports, two prioritised write ports,
// a busy scoreboard and a registered write-trace stream.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int PC_W     = PC_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  grf_multiport_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              we_a_eff, we_b_eff, commit_a, issue_eff;

  logic [1:0]        trace_valid_d, trace_valid_q;
  logic [ADDR_W-1:0] trace_reg_a_d, trace_reg_a_q, trace_reg_b_d, trace_reg_b_q;
  logic [DATA_W-1:0] trace_data_a_d, trace_data_a_q, trace_data_b_d, trace_data_b_q;
  logic [PC_W-1:0]   trace_pc_a_d, trace_pc_a_q, trace_pc_b_d, trace_pc_b_q;

  // Gating on Reset here also disables bypass while reset is held.
  assign we_a_eff  = bus.WeA && !Reset && !(ZR && bus.WaA == '0);
  assign we_b_eff  = bus.WeB && !Reset && !(ZR && bus.WaB == '0);
  assign commit_a  = we_a_eff && !(we_b_eff && bus.WaA == bus.WaB);
  assign issue_eff = bus.IssueEn && !Reset && !(ZR && bus.IssueReg == '0);

  grf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (Clock),
    .rst       (Reset),
    .issue_en  (issue_eff),
    .issue_idx (bus.IssueReg),
    .clr_a_en  (we_a_eff),
    .clr_a_idx (bus.WaA),
    .clr_b_en  (we_b_eff),
    .clr_b_idx (bus.WaB),
    .busy      (busy)
  );

  always_comb begin
    mem_d = mem_q;
    if (commit_a) mem_d[bus.WaA] = bus.WdA;
    if (we_b_eff) mem_d[bus.WaB] = bus.WdB;
  end

  always_ff @(posedge Clock) begin
    if (Reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              hit_a, hit_b;
    logic [DATA_W-1:0] rdata;

    assign idx   = bus.ReadReg[k*ADDR_W +: ADDR_W];
    assign hit_a = we_a_eff && (bus.WaA == idx);
    assign hit_b = we_b_eff && (bus.WaB == idx);

    always_comb begin
      rdata = mem_q[idx];
      if (hit_a) rdata = bus.WdA;
      if (hit_b) rdata = bus.WdB;
      if (ZR && idx == '0) rdata = '0;
    end

    assign bus.ReadData[k*DATA_W +: DATA_W] = rdata;
    // A value being bypassed this cycle is already available, so not busy.
    assign bus.ReadBusy[k] = busy[idx] && !(hit_a || hit_b);
  end

  always_comb begin
    trace_valid_d  = {we_b_eff, commit_a};
    trace_reg_a_d  = trace_reg_a_q;
    trace_data_a_d = trace_data_a_q;
    trace_pc_a_d   = trace_pc_a_q;
    trace_reg_b_d  = trace_reg_b_q;
    trace_data_b_d = trace_data_b_q;
    trace_pc_b_d   = trace_pc_b_q;
    if (commit_a) begin
      trace_reg_a_d  = bus.WaA;
      trace_data_a_d = bus.WdA;
      trace_pc_a_d   = bus.WpcA;
    end
    if (we_b_eff) begin
      trace_reg_b_d  = bus.WaB;
      trace_data_b_d = bus.WdB;
      trace_pc_b_d   = bus.WpcB;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      trace_valid_q  <= '0;
      trace_reg_a_q  <= '0;
      trace_data_a_q <= '0;
      trace_pc_a_q   <= '0;
      trace_reg_b_q  <= '0;
      trace_data_b_q <= '0;
      trace_pc_b_q   <= '0;
    end else begin
      trace_valid_q  <= trace_valid_d;
      trace_reg_a_q  <= trace_reg_a_d;
      trace_data_a_q <= trace_data_a_d;
      trace_pc_a_q   <= trace_pc_a_d;
      trace_reg_b_q  <= trace_reg_b_d;
      trace_data_b_q <= trace_data_b_d;
      trace_pc_b_q   <= trace_pc_b_d;
    end
  end

  assign bus.TraceValid = trace_valid_q;
  assign bus.TraceRegA  = trace_reg_a_q;
  assign bus.TraceDataA = trace_data_a_q;
  assign bus.TracePcA   = trace_pc_a_q;
  assign bus.TraceRegB  = trace_reg_b_q;
  assign bus.TraceDataB = trace_data_b_q;
  assign bus.TracePcB   = trace_pc_b_q;
endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport: reset, bypass, write conflicts, busy scoreboard, trace.
module tb_grf_multiport;
  import grf_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int PC_W   = 32;

  logic Clock = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  grf_multiport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .PC_W(PC_W)) bus ();

  grf_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .PC_W(PC_W), .ZERO_REG(1)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  trace_lane_t lane_a, lane_b;
  assign lane_a = '{idx: bus.TraceRegA, data: bus.TraceDataA, pc: bus.TracePcA};
  assign lane_b = '{idx: bus.TraceRegB, data: bus.TraceDataB, pc: bus.TracePcB};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd(input int k);
    return bus.ReadData[k*DATA_W +: DATA_W];
  endfunction

  task automatic set_rd(input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
    bus.ReadReg = {r1, r0};
  endtask

  // Advance one edge, then drive at posedge+1; checks happen at posedge+2.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    bus.WeA = 0; bus.WeB = 0; bus.IssueEn = 0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.ReadReg = '0;
    bus.WeA = 0; bus.WaA = '0; bus.WdA = '0; bus.WpcA = '0;
    bus.WeB = 0; bus.WaB = '0; bus.WdB = '0; bus.WpcB = '0;
    bus.IssueEn = 0; bus.IssueReg = '0;

    tick(); tick();
    Reset = 1'b0;
    #1;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(31 - i));
      #1;
      chk("rst_rd0", 64'(rd(0)), 64'h0);
      chk("rst_rd1", 64'(rd(1)), 64'h0);
      chk("rst_busy", 64'(bus.ReadBusy), 64'h0);
    end
    chk("rst_tvalid", 64'(bus.TraceValid), 64'h0);
    chk("rst_treg_a", 64'(lane_a.idx), 64'h0);

    // Port A write with same-cycle bypass.
    tick();
    bus.WeA = 1; bus.WaA = 5'd5; bus.WdA = 32'h1234_5678; bus.WpcA = 32'h3000;
    set_rd(5'd5, 5'd0);
    #1;
    chk("a_bypass", 64'(rd(0)), 64'h1234_5678);
    chk("a_bypass_busy", 64'(bus.ReadBusy[0]), 64'h0);
    tick(); idle(); #1;
    chk("a_tvalid", 64'(bus.TraceValid), 64'h1);
    chk("a_treg", 64'(lane_a.idx), 64'h5);
    chk("a_tdata", 64'(lane_a.data), 64'h1234_5678);
    chk("a_tpc", 64'(lane_a.pc), 64'h3000);
    chk("a_array", 64'(rd(0)), 64'h1234_5678);

    // Conflict: both ports write r7, B wins.
    tick();
    bus.WeA = 1; bus.WaA = 5'd7; bus.WdA = 32'hAAAA; bus.WpcA = 32'h4000;
    bus.WeB = 1; bus.WaB = 5'd7; bus.WdB = 32'hBBBB; bus.WpcB = 32'h4004;
    set_rd(5'd5, 5'd7);
    #1;
    chk("ab_bypass", 64'(rd(1)), 64'hBBBB);
    tick(); idle(); #1;
    chk("ab_tvalid", 64'(bus.TraceValid), 64'h2);
    chk("ab_treg_b", 64'(lane_b.idx), 64'h7);
    chk("ab_tdata_b", 64'(lane_b.data), 64'hBBBB);
    chk("ab_tpc_b", 64'(lane_b.pc), 64'h4004);
    chk("ab_array", 64'(rd(1)), 64'hBBBB);
    chk("a_still", 64'(rd(0)), 64'h1234_5678);
    tick(); #1;
    chk("tvalid_pulse", 64'(bus.TraceValid), 64'h0);

    // Issue r9, then B retires it.
    bus.IssueEn = 1; bus.IssueReg = 5'd9;
    set_rd(5'd9, 5'd7);
    #1;
    chk("iss_same_cyc", 64'(bus.ReadBusy[0]), 64'h0);
    tick(); idle(); #1;
    chk("iss_busy", 64'(bus.ReadBusy[0]), 64'h1);
    chk("iss_other", 64'(bus.ReadBusy[1]), 64'h0);
    tick();
    bus.WeB = 1; bus.WaB = 5'd9; bus.WdB = 32'h55; bus.WpcB = 32'h5000;
    #1;
    chk("wb_busy_byp", 64'(bus.ReadBusy[0]), 64'h0);
    chk("wb_data_byp", 64'(rd(0)), 64'h55);
    tick(); idle(); #1;
    chk("wb_busy_clr", 64'(bus.ReadBusy[0]), 64'h0);
    chk("wb_array", 64'(rd(0)), 64'h55);

    // Issue and write to r9 together: busy stays set; r0 is immutable.
    tick();
    bus.IssueEn = 1; bus.IssueReg = 5'd9;
    bus.WeA = 1; bus.WaA = 5'd9; bus.WdA = 32'h66; bus.WpcA = 32'h6000;
    #1;
    tick(); idle(); #1;
    chk("iw_busy", 64'(bus.ReadBusy[0]), 64'h1);
    chk("iw_array", 64'(rd(0)), 64'h66);
    tick();
    bus.WeA = 1; bus.WaA = 5'd0; bus.WdA = 32'hFFFF;
    bus.IssueEn = 1; bus.IssueReg = 5'd0;
    set_rd(5'd9, 5'd0);
    #1;
    chk("r0_byp", 64'(rd(1)), 64'h0);
    chk("r0_busy_byp", 64'(bus.ReadBusy[1]), 64'h0);
    tick(); idle(); #1;
    chk("r0_tvalid", 64'(bus.TraceValid), 64'h0);
    chk("r0_rd", 64'(rd(1)), 64'h0);
    chk("r0_busy", 64'(bus.ReadBusy[1]), 64'h0);

    // Seed r3, then reset coinciding with a write and an issue.
    tick();
    bus.WeA = 1; bus.WaA = 5'd3; bus.WdA = 32'h11; bus.WpcA = 32'h7000;
    tick(); idle();
    Reset = 1'b1;
    bus.WeA = 1; bus.WaA = 5'd3; bus.WdA = 32'h77; bus.WpcA = 32'h7004;
    bus.IssueEn = 1; bus.IssueReg = 5'd4;
    set_rd(5'd3, 5'd9);
    #1;
    chk("rst_no_byp", 64'(rd(0)), 64'h11);
    chk("pre_rst_busy9", 64'(bus.ReadBusy[1]), 64'h1);
    tick(); idle(); Reset = 1'b0;
    #1;
    chk("post_rst_r3", 64'(rd(0)), 64'h0);
    chk("post_rst_r9", 64'(rd(1)), 64'h0);
    chk("post_rst_busy9", 64'(bus.ReadBusy[1]), 64'h0);
    chk("post_rst_tvalid", 64'(bus.TraceValid), 64'h0);
    chk("post_rst_tpc_a", 64'(lane_a.pc), 64'h0);
    set_rd(5'd4, 5'd3);
    #1;
    chk("post_rst_busy4", 64'(bus.ReadBusy[0]), 64'h0);
    tick(); #1;
    chk("post_rst_r3_hold", 64'(rd(1)), 64'h0);
    chk("post_rst_tvalid2", 64'(bus.TraceValid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
